ad9866_port_emu: RTL and testbench
==================================

Name: ad9866_port_emu

Overview:
- Synthesizable model of the AD9866 side of the full-duplex 6-bit nibble interface.
- Receives interleaved TX nibbles from the FPGA-side AD9866 controller and decodes them into 12-bit words.
- Sources interleaved RX nibbles with rxsync framing, either from a ramp generator or by looping back the decoded TX words.
- Used in loopback test builds and in simulation benches that stand in for the converter.

Parameters:
- RAMP_STEP, 12'd1, increment added to the ramp sample once per RX word (12-bit, wraps).
- RAMP_INIT, 12'd0, ramp value after reset.

Ports:
- clk  input  1  2x sample clock. One nibble per cycle. Single clock domain.
- rst_n  input  1  asynchronous active-low reset.
- rffe_ad9866_tx  input  6  TX nibble from the controller.
- rffe_ad9866_txsync  input  1  TX framing: 0 = high nibble [11:6], 1 = low nibble [5:0].
- rffe_ad9866_txquiet_n  input  1  1 = TX active; 0 = TX quiet.
- rffe_ad9866_mode  input  1  1 = full-duplex nibble mode; 0 = RX output disabled.
- loopback_en  input  1  1 = RX source is the last decoded TX word; 0 = ramp.
- err_clr  input  1  synchronous clear of frame_err_cnt.
- rffe_ad9866_rx  output  6  RX nibble to the controller.
- rffe_ad9866_rxsync  output  1  RX framing: 0 = high nibble, 1 = low nibble.
- tx_word  output  12  last decoded TX word.
- tx_valid  output  1  one-cycle pulse when tx_word updates.
- frame_err_cnt  output  8  saturating TX framing-error count.

Behaviour:
Reset (rst_n low, asynchronous):
- rffe_ad9866_rx=0, rffe_ad9866_rxsync=0, tx_word=0, tx_valid=0, frame_err_cnt=0.
- ramp=RAMP_INIT, loop_word=0, ph=0, hi_valid=0.
- Deassertion takes effect on the next clk edge.

RX framer (all outputs registered):
- ph toggles every clk while mode=1.
- ph=0 cycle: sample src latched (loopback_en ? loop_word : ramp). Outputs rx=src[11:6], rxsync=0.
- ph=1 cycle: outputs rx=src_latched[5:0], rxsync=1.
- Ramp advances by RAMP_STEP (mod 4096) on every ph=1 cycle, whether or not it is selected.
- loopback_en is sampled only at ph=0, so a change never splits a word.
- mode=0:
  - ph is forced to 0; rx=0 and rxsync=0 from the next edge.
  - Ramp holds.
  - When mode returns to 1, the first output is a high nibble.

TX deframer:
- txquiet_n=0: hi_valid cleared, no tx_valid, no error counting.
- txquiet_n=1, txsync=0:
  - hi_reg<=nibble, hi_valid<=1.
  - If hi_valid was already 1 (two high nibbles in a row): frame error; hi_reg is overwritten.
- txquiet_n=1, txsync=1:
  - If hi_valid=1: tx_word<={hi_reg,nibble}, tx_valid=1 on the next cycle, loop_word<= same value, hi_valid<=0.
  - Else (low nibble without a preceding high nibble): frame error, nibble dropped.
- Latency: low nibble at the pins on edge N gives tx_word/tx_valid visible after edge N+1 (one register stage).
- A loopback word reaches rffe_ad9866_rx at the first ph=0 cycle after loop_word updates.

frame_err_cnt:
- Increments by 1 per error and saturates at 8'hFF.
- err_clr sets it to 0. If an error occurs in the same cycle, err_clr wins and the count becomes 0.

Reset mid-word: a partially assembled TX word is discarded, and any RX word in flight is truncated.

Test Plan:
- Ramp: reset with RAMP_STEP=1, mode=1, loopback_en=0 -> rx/rxsync sequence is (0x00,0),(0x00,1),(0x00,0),(0x01,1),(0x00,0),(0x02,1), i.e. words 0,1,2,…. Word 4095 is followed by 0.
- TX decode: drive (0x2A,txsync=0),(0x15,txsync=1) with txquiet_n=1 -> one edge later tx_word=12'hA95 with a single-cycle tx_valid. frame_err_cnt stays 0.
- Loopback: loopback_en=1, send TX word 12'h7FF -> next RX word is (0x1F,0),(0x3F,1). tx_word is unchanged until the next TX word.
- Framing errors:
  - Two consecutive txsync=0 nibbles -> frame_err_cnt=1.
  - A txsync=1 nibble after txquiet_n dropped -> frame_err_cnt=2, no tx_valid.
  - 300 errors -> count holds at 0xFF.
  - err_clr asserted together with an error -> 0.
- Mode/quiet: mode=0 for 5 cycles -> rx=0, rxsync=0, ramp frozen. On re-enable, the first output is a high nibble with rxsync=0. txquiet_n=0 between a high and a low nibble -> no word produced, no error counted.
- Async reset: assert rst_n low between clock edges during an active TX and RX word -> all outputs go to 0 immediately. After release, the RX sequence restarts from RAMP_INIT.

Source files
------------

// File: rtl/ad9866_port_emu.sv
// AD9866-side emulation of the full-duplex 6-bit nibble interface.
// Deframes interleaved TX nibbles into 12-bit words and sources framed RX
// nibbles from either a free-running ramp or the last decoded TX word.
module ad9866_port_emu #(
  parameter logic [11:0] RAMP_STEP = 12'd1,
  parameter logic [11:0] RAMP_INIT = 12'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  rffe_ad9866_tx,
  input  logic        rffe_ad9866_txsync,
  input  logic        rffe_ad9866_txquiet_n,
  input  logic        rffe_ad9866_mode,
  input  logic        loopback_en,
  input  logic        err_clr,
  output logic [5:0]  rffe_ad9866_rx,
  output logic        rffe_ad9866_rxsync,
  output logic [11:0] tx_word,
  output logic        tx_valid,
  output logic [7:0]  frame_err_cnt
);

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } ph_t;

  ph_t         ph, ph_nxt;
  logic [11:0] ramp;
  logic [11:0] src_lat;
  logic [11:0] src_sel;
  logic [11:0] loop_word;

  logic [5:0]  tx_q;
  logic        txsync_q;
  logic        txquiet_n_q;
  logic [5:0]  hi_reg;
  logic        hi_valid;
  logic        frame_err;

  // RX phase register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ph <= PH_HI;
    else        ph <= ph_nxt;
  end

  // RX phase sequencing: alternate while enabled, park on the high nibble otherwise
  always_comb begin
    ph_nxt = PH_HI;
    if (rffe_ad9866_mode)
      ph_nxt = (ph == PH_HI) ? PH_LO : PH_HI;
  end

  assign src_sel = loopback_en ? loop_word : ramp;

  // RX datapath: latch the source word on the high phase, emit its low half next
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp               <= RAMP_INIT;
      src_lat            <= '0;
      rffe_ad9866_rx     <= '0;
      rffe_ad9866_rxsync <= 1'b0;
    end else if (!rffe_ad9866_mode) begin
      rffe_ad9866_rx     <= '0;
      rffe_ad9866_rxsync <= 1'b0;
    end else if (ph == PH_HI) begin
      src_lat            <= src_sel;
      rffe_ad9866_rx     <= src_sel[11:6];
      rffe_ad9866_rxsync <= 1'b0;
    end else begin
      rffe_ad9866_rx     <= src_lat[5:0];
      rffe_ad9866_rxsync <= 1'b1;
      ramp               <= ramp + RAMP_STEP;
    end
  end

  // TX pin capture stage; the deframer works from these registered copies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q        <= '0;
      txsync_q    <= 1'b0;
      txquiet_n_q <= 1'b0;
    end else begin
      tx_q        <= rffe_ad9866_tx;
      txsync_q    <= rffe_ad9866_txsync;
      txquiet_n_q <= rffe_ad9866_txquiet_n;
    end
  end

  // Framing error: a second high nibble, or a low nibble with no high pending
  always_comb begin
    frame_err = 1'b0;
    if (txquiet_n_q)
      frame_err = txsync_q ? !hi_valid : hi_valid;
  end

  // TX deframer: pair high and low nibbles into a word and mirror it for loopback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg    <= '0;
      hi_valid  <= 1'b0;
      tx_word   <= '0;
      loop_word <= '0;
      tx_valid  <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      if (!txquiet_n_q) begin
        hi_valid <= 1'b0;
      end else if (!txsync_q) begin
        hi_reg   <= tx_q;
        hi_valid <= 1'b1;
      end else if (hi_valid) begin
        tx_word   <= {hi_reg, tx_q};
        loop_word <= {hi_reg, tx_q};
        tx_valid  <= 1'b1;
        hi_valid  <= 1'b0;
      end
    end
  end

  // Saturating framing-error counter; a clear overrides a coincident error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_err_cnt <= '0;
    else if (err_clr)
      frame_err_cnt <= '0;
    else if (frame_err && frame_err_cnt != '1)
      frame_err_cnt <= frame_err_cnt + 8'd1;
  end

endmodule

// File: tb/tb_ad9866_port_emu.sv
// Scoreboard bench for ad9866_port_emu: expected RX nibbles and TX words are
// queued as stimulus is applied and compared as the DUT produces them.
module tb_ad9866_port_emu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  rffe_ad9866_tx = '0;
  logic        rffe_ad9866_txsync = 1'b0;
  logic        rffe_ad9866_txquiet_n = 1'b0;
  logic        rffe_ad9866_mode = 1'b1;
  logic        loopback_en = 1'b0;
  logic        err_clr = 1'b0;
  logic [5:0]  rffe_ad9866_rx;
  logic        rffe_ad9866_rxsync;
  logic [11:0] tx_word;
  logic        tx_valid;
  logic [7:0]  frame_err_cnt;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned edge_cnt = 0;

  logic [6:0]  rxq[$];
  logic [11:0] txq[$];

  ad9866_port_emu #(.RAMP_STEP(12'd1), .RAMP_INIT(12'd0)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .rffe_ad9866_tx       (rffe_ad9866_tx),
    .rffe_ad9866_txsync   (rffe_ad9866_txsync),
    .rffe_ad9866_txquiet_n(rffe_ad9866_txquiet_n),
    .rffe_ad9866_mode     (rffe_ad9866_mode),
    .loopback_en          (loopback_en),
    .err_clr              (err_clr),
    .rffe_ad9866_rx       (rffe_ad9866_rx),
    .rffe_ad9866_rxsync   (rffe_ad9866_rxsync),
    .tx_word              (tx_word),
    .tx_valid             (tx_valid),
    .frame_err_cnt        (frame_err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [11:0] w);
    rxq.push_back({w[11:6], 1'b0});
    rxq.push_back({w[5:0], 1'b1});
  endtask

  task automatic tick();
    logic [6:0]  e;
    logic [11:0] w;
    @(posedge clk);
    #1;
    edge_cnt++;
    if (rxq.size() != 0) begin
      e = rxq.pop_front();
      check("rx", {25'd0, rffe_ad9866_rx, rffe_ad9866_rxsync}, {25'd0, e});
    end
    if (tx_valid === 1'b1) begin
      if (txq.size() != 0) begin
        w = txq.pop_front();
        check("tx_word", {20'd0, tx_word}, {20'd0, w});
      end else begin
        check("tx_valid_spurious", {31'd0, tx_valid}, 32'd0);
      end
    end
  endtask

  task automatic tx_nib(input logic [5:0] n, input logic s);
    rffe_ad9866_txquiet_n = 1'b1;
    rffe_ad9866_tx        = n;
    rffe_ad9866_txsync    = s;
    tick();
  endtask

  task automatic tx_idle();
    rffe_ad9866_txquiet_n = 1'b0;
    rffe_ad9866_txsync    = 1'b0;
    rffe_ad9866_tx        = '0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rx"},     {26'd0, rffe_ad9866_rx}, 32'd0);
    check({tag, "_rxsync"}, {31'd0, rffe_ad9866_rxsync}, 32'd0);
    check({tag, "_txword"}, {20'd0, tx_word}, 32'd0);
    check({tag, "_txvalid"},{31'd0, tx_valid}, 32'd0);
    check({tag, "_errcnt"}, {24'd0, frame_err_cnt}, 32'd0);
  endtask

  task automatic do_reset();
    check("txq_left", txq.size(), 32'd0);
    check("rxq_left", rxq.size(), 32'd0);
    #2;
    rst_n = 1'b0;
    tx_idle();
    rffe_ad9866_mode = 1'b1;
    loopback_en = 1'b0;
    err_clr = 1'b0;
    rxq.delete();
    txq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    edge_cnt = 0;
  endtask

  initial begin
    // reset state
    #3;
    check_zero_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    edge_cnt = 0;

    // ramp through the 12-bit wrap
    for (int w = 0; w < 4100; w++) push_word(12'(w));
    repeat (8200) tick();

    // TX decode with latency check
    do_reset();
    tx_nib(6'h2A, 1'b0);
    tx_nib(6'h15, 1'b1);
    check("dec_valid_early", {31'd0, tx_valid}, 32'd0);
    tx_idle();
    txq.push_back(12'hA95);
    tick();
    check("dec_valid", {31'd0, tx_valid}, 32'd1);
    tick();
    check("dec_pulse_end", {31'd0, tx_valid}, 32'd0);
    check("dec_word_hold", {20'd0, tx_word}, 32'hA95);
    check("dec_errcnt", {24'd0, frame_err_cnt}, 32'd0);

    // loopback, with loopback_en dropped mid-word
    do_reset();
    loopback_en = 1'b1;
    tx_nib(6'h1F, 1'b0);
    tx_nib(6'h3F, 1'b1);
    tx_idle();
    txq.push_back(12'h7FF);
    tick();
    if (edge_cnt % 2 == 1) tick();
    rxq.push_back({6'h1F, 1'b0});
    tick();
    loopback_en = 1'b0;
    rxq.push_back({6'h3F, 1'b1});
    tick();
    push_word(12'(edge_cnt / 2));
    tick();
    tick();
    check("lb_word_hold", {20'd0, tx_word}, 32'h7FF);
    check("lb_valid_low", {31'd0, tx_valid}, 32'd0);

    // framing errors
    do_reset();
    tx_nib(6'h01, 1'b0);
    tx_nib(6'h02, 1'b0);
    tx_idle();
    tick();
    tick();
    check("err_two_hi", {24'd0, frame_err_cnt}, 32'd1);
    tx_nib(6'h03, 1'b1);
    tx_idle();
    tick();
    tick();
    check("err_lo_alone", {24'd0, frame_err_cnt}, 32'd2);
    rffe_ad9866_txquiet_n = 1'b1;
    rffe_ad9866_txsync = 1'b1;
    rffe_ad9866_tx = 6'h05;
    repeat (300) tick();
    tx_idle();
    tick();
    tick();
    check("err_saturate", {24'd0, frame_err_cnt}, 32'hFF);
    tx_nib(6'h05, 1'b1);
    err_clr = 1'b1;
    tick();
    check("err_clr_wins", {24'd0, frame_err_cnt}, 32'd0);
    err_clr = 1'b0;
    tx_idle();
    tick();
    tick();
    check("err_after_clr", {24'd0, frame_err_cnt}, 32'd1);

    // mode disable mid-word, then quiet gap inside a TX word
    do_reset();
    for (int w = 0; w < 70; w++) push_word(12'(w));
    repeat (140) tick();
    rxq.push_back({6'd1, 1'b0});
    tick();
    rffe_ad9866_mode = 1'b0;
    repeat (5) rxq.push_back(7'd0);
    repeat (5) tick();
    rffe_ad9866_mode = 1'b1;
    push_word(12'd70);
    push_word(12'd71);
    repeat (4) tick();
    tx_nib(6'h2A, 1'b0);
    rffe_ad9866_txquiet_n = 1'b0;
    rffe_ad9866_tx = 6'h15;
    rffe_ad9866_txsync = 1'b1;
    repeat (3) tick();
    check("quiet_errcnt", {24'd0, frame_err_cnt}, 32'd0);
    tx_nib(6'h2A, 1'b0);
    tx_nib(6'h15, 1'b1);
    tx_idle();
    txq.push_back(12'hA95);
    tick();
    tick();
    check("quiet_recover", {20'd0, tx_word}, 32'hA95);

    // asynchronous reset during active TX and RX words
    do_reset();
    repeat (151) tick();
    tx_nib(6'h2A, 1'b0);
    txq.push_back(12'hA95);
    tx_nib(6'h15, 1'b1);
    tx_nib(6'h01, 1'b1);
    tx_nib(6'h33, 1'b0);
    tick();
    check("pre_rst_word", {20'd0, tx_word}, 32'hA95);
    check("pre_rst_err", {24'd0, frame_err_cnt}, 32'd1);
    check("txq_left", txq.size(), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async");
    tx_idle();
    @(negedge clk);
    rst_n = 1'b1;
    edge_cnt = 0;
    push_word(12'd0);
    push_word(12'd1);
    push_word(12'd2);
    tx_nib(6'h15, 1'b1);
    tx_idle();
    repeat (5) tick();
    check("post_rst_hi_dropped", {24'd0, frame_err_cnt}, 32'd1);
    check("post_rst_word", {20'd0, tx_word}, 32'd0);
    check("txq_left", txq.size(), 32'd0);
    check("rxq_left", rxq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
